// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
//   SZ_BYTE/SZ_HALF/SZ_WORD : req_size encodings (2'b11 is illegal)
//   state_t                 : responder FSM states
//   size_bytes()            : access width in bytes for a size encoding
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // The illegal encoding maps to 4 so the range check stays conservative;
  // it is flagged as an error independently.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational little-endian lane steering.
//   addr_lo     in  2   byte offset within the word
//   size        in  2   access size encoding
//   is_unsigned in  1   zero-extend loads when 1
//   rword       in  32  storage word containing the access
//   wdata       in  32  store data (low bytes significant)
//   byte_en     out 4   lanes written by a store
//   wdata_lanes out 32  store data replicated onto every candidate lane
//   rdata_ext   out 32  load data shifted down and extended
//   misaligned  out 1   halfword/word not naturally aligned
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign shifted = rword >> {addr_lo, 3'b000};

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = '0;
    rdata_ext   = '0;
    misaligned  = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = is_unsigned ? {24'd0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        byte_en     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = is_unsigned ? {16'd0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
        misaligned  = addr_lo[0];
      end
      SZ_WORD: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
        misaligned  = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with wait states.
//   clock        in  1   rising-edge clock
//   reset        in  1   synchronous active-high reset (also clears storage)
//   req_valid    in  1   request present
//   req_ready    out 1   high only in IDLE
//   req_write    in  1   1 = store, 0 = load
//   req_size     in  2   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned in  1   zero-extend loads
//   req_addr     in  32  byte address
//   req_wdata    in  32  store data
//   rsp_valid    out 1   one-cycle response pulse
//   rsp_rdata    out 32  extended load data, 0 for stores/errors
//   rsp_error    out 1   misaligned, out of range or illegal size
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept, commit;

  logic            lat_write, lat_unsigned;
  logic [1:0]      lat_size;
  logic [31:0]     lat_addr, lat_wdata;

  logic            cur_write, cur_unsigned;
  logic [1:0]      cur_size;
  logic [31:0]     cur_addr, cur_wdata;

  logic [31:0]     mem_q [WORDS];
  logic [AW-3:0]   word_idx;
  logic [32:0]     end_addr;
  logic            out_of_range, illegal, misaligned, err;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_lanes, rdata_ext;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // operation is taken straight from the request inputs while in IDLE.
  assign cur_write    = (state_q == IDLE) ? req_write    : lat_write;
  assign cur_size     = (state_q == IDLE) ? req_size     : lat_size;
  assign cur_unsigned = (state_q == IDLE) ? req_unsigned : lat_unsigned;
  assign cur_addr     = (state_q == IDLE) ? req_addr     : lat_addr;
  assign cur_wdata    = (state_q == IDLE) ? req_wdata    : lat_wdata;

  // Full 32-bit address takes part in the range check; no wrap-around.
  assign end_addr     = {1'b0, cur_addr} + 33'(size_bytes(cur_size));
  assign out_of_range = end_addr > 33'(DEPTH_BYTES);
  assign illegal      = (cur_size == 2'b11);
  assign err          = illegal | misaligned | out_of_range;
  assign word_idx     = cur_addr[AW-1:2];

  dmem_lane_align u_align (
    .addr_lo     (cur_addr[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_unsigned),
    .rword       (mem_q[word_idx]),
    .wdata       (cur_wdata),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned)
  );

  assign req_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State/counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clock) begin
    if (accept) begin
      lat_write    <= req_write;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata;
    end
  end

  // Response register: loaded on the RESP-entry edge, cleared otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (commit) begin
      rsp_valid <= 1'b1;
      rsp_error <= err;
      rsp_rdata <= (err || cur_write) ? 32'd0 : rdata_ext;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end
  end

  // Storage: stores commit on the RESP-entry edge only when error-free
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (commit && cur_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  logic        z_valid = 1'b0, z_write = 1'b0, z_unsigned = 1'b0;
  logic [1:0]  z_size = 2'b00;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic        z_ready, z_rsp_valid, z_rsp_error;
  logic [31:0] z_rsp_rdata;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error));

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(z_valid), .req_ready(z_ready),
    .req_write(z_write), .req_size(z_size), .req_unsigned(z_unsigned),
    .req_addr(z_addr), .req_wdata(z_wdata), .rsp_valid(z_rsp_valid),
    .rsp_rdata(z_rsp_rdata), .rsp_error(z_rsp_error));

  int tests = 0, fails = 0;
  int cyc = 0;
  bit started = 1'b0;

  logic [7:0]  mmem [DEPTH];
  bit          have_pend = 1'b0;
  int          pend_due = 0;
  logic [31:0] pend_rdata = '0;
  logic        pend_err = 1'b0;
  bit          exp_v;

  bit          z_phase = 1'b0, z_exp_ready = 1'b1, z_pend_err = 1'b0;
  int          z_accepts = 0, z_rsps = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int nbytes_of(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
  endfunction

  function automatic bit model_err(logic [1:0] s, logic [31:0] a);
    int n;
    logic [63:0] a64;
    n = nbytes_of(s);
    a64 = {32'd0, a};
    if (n == 0) return 1'b1;
    if ((a64 % 64'(n)) != 0) return 1'b1;
    if (a64 + 64'(n) > 64'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  // Byte-array reference: applies a store, or assembles and extends a load.
  function automatic void model_access(input logic w, input logic [1:0] s, input logic u,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] val;
    er = model_err(s, a);
    rd = '0;
    if (er) return;
    n = nbytes_of(s);
    if (w) begin
      for (int i = 0; i < n; i++) mmem[a + i] = wd[8*i +: 8];
    end else begin
      val = '0;
      for (int i = 0; i < n; i++) val = val | ({24'd0, mmem[a + i]} << (8 * i));
      if (!u && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
      rd = val;
    end
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clock) begin
    if (started) begin
      exp_v = have_pend && (pend_due == cyc);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      check("rsp_rdata", rsp_rdata, exp_v ? pend_rdata : 32'd0);
      check("rsp_error", 32'(rsp_error), exp_v ? 32'(pend_err) : 32'd0);
      check("req_ready", 32'(req_ready), 32'(!(have_pend && cyc <= pend_due)));
      if (have_pend && cyc >= pend_due) have_pend = 1'b0;
    end
  end

  // Zero-wait instance with req_valid held high: ready alternates each cycle.
  always @(negedge clock) begin
    if (z_phase) begin
      check("z_ready", 32'(z_ready), 32'(z_exp_ready));
      check("z_rsp_valid", 32'(z_rsp_valid), 32'(!z_exp_ready));
      if (z_rsp_valid) begin
        z_rsps++;
        check("z_rsp_error", 32'(z_rsp_error), 32'(z_pend_err));
        check("z_rsp_rdata", z_rsp_rdata, 32'd0);
      end
      if (z_exp_ready) begin
        z_accepts++;
        z_pend_err = model_err(z_size, z_addr);
      end
      z_exp_ready = !z_exp_ready;
    end
  end

  task automatic do_req(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input bit wait_rsp,
                        output logic [31:0] got_rd, output logic got_err, output int lat);
    int n;
    int acc;
    got_rd = '0;
    got_err = 1'b0;
    lat = -1;
    @(negedge clock);
    #1;
    req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    acc = cyc;
    model_access(w, s, u, a, wd, pend_rdata, pend_err);
    pend_due = acc + WAITC;
    have_pend = 1'b1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (!wait_rsp) return;
    n = 0;
    while (n < 50) begin
      @(negedge clock);
      if (rsp_valid) begin
        got_rd = rsp_rdata;
        got_err = rsp_error;
        lat = cyc - acc + 1;
        break;
      end
      n++;
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 50 cycles");
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #1;
    reset = 1'b1;
    have_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = 8'h00;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [1:0]  s;
    logic [31:0] a;
    int          sel;

    for (int i = 0; i < DEPTH; i++) mmem[i] = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    started = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, rd, er, lat);
    check("sw_latency", 32'(lat), 32'd3);
    check("sw_rdata", rd, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
    check("lw_latency", 32'(lat), 32'd3);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_error", 32'(er), 32'd0);

    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 1'b1, rd, er, lat);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1, rd, er, lat);
    check("lh_22", rd, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1, rd, er, lat);
    check("lhu_22", rd, 32'h00008001);
    do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 1'b1, rd, er, lat);
    check("lbu_23", rd, 32'h00000080);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, rd, er, lat);
    check("lw_20", rd, 32'h80010000);

    do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000FFFF, 1'b1, rd, er, lat);
    check("sh_21_error", 32'(er), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h21, 32'h0, 1'b1, rd, er, lat);
    check("lw_21_error", 32'(er), 32'd1);
    check("lw_21_rdata", rd, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, rd, er, lat);
    check("lw_20_unchanged", rd, 32'h80010000);
    check("lw_20_error", 32'(er), 32'd0);

    do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 1'b1, rd, er, lat);
    check("lw_3fc_error", 32'(er), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b1, rd, er, lat);
    check("lw_400_error", 32'(er), 32'd1);
    do_req(1'b0, 2'd1, 1'b0, 32'h3FF, 32'h0, 1'b1, rd, er, lat);
    check("lh_3ff_error", 32'(er), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, rd, er, lat);
    check("size11_error", 32'(er), 32'd1);

    // Store abandoned by reset while waiting, then read back.
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, 1'b0, rd, er, lat);
    apply_reset();
    @(negedge clock);
    check("post_reset_valid", 32'(rsp_valid), 32'd0);
    check("post_reset_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, rd, er, lat);
    check("lw_40_after_reset", rd, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
    check("lw_10_cleared", rd, 32'd0);

    for (int k = 0; k < 150; k++) begin
      s = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, 63));
      else if (sel < 9) a = 32'($urandom_range(DEPTH - 8, DEPTH + 3));
      else              a = $urandom;
      do_req(1'($urandom), s, 1'($urandom), a, $urandom, 1'b1, rd, er, lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    // Zero-wait instance: continuous req_valid, random loads.
    @(posedge clock);
    #1;
    z_valid = 1'b1;
    z_size = 2'($urandom_range(0, 3));
    z_addr = 32'($urandom_range(0, DEPTH + 4));
    z_phase = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == 39) begin
        #1;
        z_valid = 1'b0;
        z_phase = 1'b0;
      end else begin
        @(posedge clock);
        #1;
        z_size = 2'($urandom_range(0, 3));
        z_addr = 32'($urandom_range(0, DEPTH + 4));
      end
    end
    check("z_accept_count", 32'(z_accepts), 32'd40 / 2);
    check("z_rsp_count", 32'(z_rsps), 32'(z_accepts));

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
